// File: rtl/mem_arb_pkg.sv
// Shared parameters and helpers for the round-robin memory arbiter.
// Sizing defaults and the pointer-width helper used by every arbiter file.
package mem_arb_pkg;

   localparam int DefNumReq    = 4;
   localparam int DefElemWidth = 8;
   localparam int DefAddrWidth = 8;

   // A single requester still needs a 1-bit pointer so port widths stay legal.
   function automatic int ptr_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/mem_rr_arbiter_mem_core.sv
// Single-port storage array: combinational read of the addressed word,
// synchronous write. Contents are never reset.
module mem_core
   import mem_arb_pkg::*;
#(
   parameter int ElemWidth = DefElemWidth,
   parameter int AddrWidth = DefAddrWidth
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [ElemWidth-1:0] wdata_i,
   output logic [ElemWidth-1:0] rdata_o
);

   localparam int Depth = 2 ** AddrWidth;

   logic [ElemWidth-1:0] mem_r [Depth];

   assign rdata_o = mem_r[addr_i];

   // Write port; rdata_o shows pre-write content during the write cycle.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_r[addr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Round-robin picker: first eligible requester at or after ptr, returned
// as a one-hot grant plus its binary index.
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter int NumReq   = DefNumReq,
   parameter int PtrWidth = ptr_width(NumReq)
) (
   input  logic [NumReq-1:0]   elig,
   input  logic [PtrWidth-1:0] ptr,
   output logic [NumReq-1:0]   grant,
   output logic [PtrWidth-1:0] idx,
   output logic                any
);

   // Walk ptr, ptr+1, ... and latch the first hit; later hits are masked by any.
   always_comb begin
      int  cand;
      logic hit;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      hit   = 1'b0;
      for (int k = 0; k < NumReq; k++) begin
         cand        = (int'(ptr) + k) % NumReq;
         hit         = !any && elig[cand];
         grant[cand] = grant[cand] | hit;
         idx         = hit ? PtrWidth'(cand) : idx;
         any         = any | hit;
      end
   end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port mem_core between NumReq
// requesters, with one registered response slot per requester.
module mem_rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NumReq    = DefNumReq,
   parameter int ElemWidth = DefElemWidth,
   parameter int AddrWidth = DefAddrWidth
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NumReq-1:0]             req_valid_i,
   output logic [NumReq-1:0]             req_ready_o,
   input  logic [NumReq-1:0]             req_we_i,
   input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
   input  logic [NumReq*ElemWidth-1:0]   req_wdata_i,
   output logic [NumReq-1:0]             rsp_valid_o,
   input  logic [NumReq-1:0]             rsp_ready_i,
   output logic [NumReq*ElemWidth-1:0]   rsp_data_o
);

   localparam int PtrWidth = ptr_width(NumReq);

   typedef struct packed {
      logic                 we;
      logic [AddrWidth-1:0] addr;
      logic [ElemWidth-1:0] wdata;
   } req_t;

   logic [NumReq-1:0]                 elig_s;
   logic [NumReq-1:0]                 grant_s;
   logic [PtrWidth-1:0]               gidx_s;
   logic                              any_s;
   logic [PtrWidth-1:0]               ptr_r;
   logic [PtrWidth-1:0]               ptr_next_s;
   req_t                              mreq_s;
   logic [ElemWidth-1:0]              rdata_s;
   logic [NumReq-1:0]                 rsp_valid_r;
   logic [NumReq-1:0][ElemWidth-1:0]  rsp_data_r;

   // A requester may issue only when its response slot is empty or draining now.
   assign elig_s = req_valid_i & (~rsp_valid_r | rsp_ready_i) & {NumReq{~rst_i}};

   rr_pick #(
      .NumReq   (NumReq),
      .PtrWidth (PtrWidth)
   ) u_pick (
      .elig  (elig_s),
      .ptr   (ptr_r),
      .grant (grant_s),
      .idx   (gidx_s),
      .any   (any_s)
   );

   assign req_ready_o = grant_s;

   // AND-OR request mux; grant is one-hot so at most one lane contributes.
   always_comb begin
      mreq_s = '0;
      for (int i = 0; i < NumReq; i++) begin
         mreq_s.we    = mreq_s.we | (grant_s[i] & req_we_i[i]);
         mreq_s.addr  = mreq_s.addr
                      | ({AddrWidth{grant_s[i]}} & req_addr_i[i*AddrWidth +: AddrWidth]);
         mreq_s.wdata = mreq_s.wdata
                      | ({ElemWidth{grant_s[i]}} & req_wdata_i[i*ElemWidth +: ElemWidth]);
      end
   end

   mem_core #(
      .ElemWidth (ElemWidth),
      .AddrWidth (AddrWidth)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (mreq_s.we),
      .addr_i  (mreq_s.addr),
      .wdata_i (mreq_s.wdata),
      .rdata_o (rdata_s)
   );

   assign ptr_next_s = !any_s ? ptr_r
                     : (gidx_s == PtrWidth'(NumReq - 1)) ? PtrWidth'(0)
                     : gidx_s + PtrWidth'(1);

   // Pointer and response slots; a grant refills a slot even while it drains.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_r       <= '0;
         rsp_valid_r <= '0;
         rsp_data_r  <= '0;
      end else begin
         ptr_r <= ptr_next_s;
         for (int i = 0; i < NumReq; i++) begin
            if (grant_s[i]) begin
               rsp_valid_r[i] <= 1'b1;
               rsp_data_r[i]  <= rdata_s;
            end else if (rsp_ready_i[i]) begin
               rsp_valid_r[i] <= 1'b0;
            end
         end
      end
   end

   assign rsp_valid_o = rsp_valid_r;
   assign rsp_data_o  = rsp_data_r;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: a vector table for reset, read/write
// and rotation, plus hand sequences for stalled responses and pointer reset.
module tb_mem_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready;
   logic [31:0] req_addr, req_wdata, rsp_data;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   mem_rr_arbiter #(.NumReq(4), .ElemWidth(8), .AddrWidth(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  valid, we, rrdy;
      logic [31:0] addr, wdata;
      logic [3:0]  exp_ready, exp_rv, dmask;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic [3:0] v, input logic [3:0] w,
                               input logic [3:0] rr, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] er, input logic [3:0] ev, input logic [3:0] m,
                               input logic [31:0] ed);
      vec_t x;
      x.rst = r; x.valid = v; x.we = w; x.rrdy = rr; x.addr = a; x.wdata = d;
      x.exp_ready = er; x.exp_rv = ev; x.dmask = m; x.exp_data = ed;
      vecs.push_back(x);
   endfunction

   function automatic logic [31:0] lanes(input logic [3:0] m);
      logic [31:0] r;
      r = 32'h0;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{m[i]}};
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] w,
                        input logic [3:0] rr, input logic [31:0] a, input logic [31:0] d);
      rst = r; req_valid = v; req_we = w; rsp_ready = rr; req_addr = a; req_wdata = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] exp_g [9];

   initial begin
      // rst valid we rrdy addr wdata | ready rsp_valid data_mask data
      add(1'b1, 4'hF, 4'h0, 4'hF, 32'h0, 32'h0,               4'h0, 4'h0, 4'hF, 32'h0);
      add(1'b1, 4'hF, 4'h0, 4'hF, 32'h0, 32'h0,               4'h0, 4'h0, 4'hF, 32'h0);
      add(1'b0, 4'h1, 4'h1, 4'hF, 32'h10, 32'hA5,             4'h1, 4'h1, 4'h0, 32'h0);
      add(1'b0, 4'h1, 4'h0, 4'hF, 32'h10, 32'h0,              4'h1, 4'h1, 4'h1, 32'hA5);
      add(1'b0, 4'h0, 4'h0, 4'hF, 32'h10, 32'h0,              4'h0, 4'h0, 4'h1, 32'hA5);
      add(1'b0, 4'h4, 4'h4, 4'hF, 32'h00100000, 32'h003C0000, 4'h4, 4'h4, 4'h4, 32'h00A50000);
      add(1'b0, 4'h4, 4'h0, 4'hF, 32'h00100000, 32'h0,        4'h4, 4'h4, 4'h4, 32'h003C0000);
      add(1'b0, 4'h0, 4'h0, 4'hF, 32'h0, 32'h0,               4'h0, 4'h0, 4'h4, 32'h003C0000);
      add(1'b1, 4'h0, 4'h0, 4'hF, 32'h0, 32'h0,               4'h0, 4'h0, 4'hF, 32'h0);
      add(1'b0, 4'hF, 4'h0, 4'hF, 32'h10101010, 32'h0,        4'h1, 4'h1, 4'h1, 32'h3C3C3C3C);
      add(1'b0, 4'hF, 4'h0, 4'hF, 32'h10101010, 32'h0,        4'h2, 4'h2, 4'h2, 32'h3C3C3C3C);
      add(1'b0, 4'hF, 4'h0, 4'hF, 32'h10101010, 32'h0,        4'h4, 4'h4, 4'h4, 32'h3C3C3C3C);
      add(1'b0, 4'hF, 4'h0, 4'hF, 32'h10101010, 32'h0,        4'h8, 4'h8, 4'h8, 32'h3C3C3C3C);
      add(1'b0, 4'hF, 4'h0, 4'hF, 32'h10101010, 32'h0,        4'h1, 4'h1, 4'h1, 32'h3C3C3C3C);
      add(1'b0, 4'hF, 4'h0, 4'hF, 32'h10101010, 32'h0,        4'h2, 4'h2, 4'h2, 32'h3C3C3C3C);
      add(1'b0, 4'h0, 4'h0, 4'hF, 32'h0, 32'h0,               4'h0, 4'h0, 4'h0, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].valid, vecs[i].we, vecs[i].rrdy, vecs[i].addr, vecs[i].wdata);
         #1;
         chk($sformatf("v%0d req_ready", i), {28'h0, req_ready}, {28'h0, vecs[i].exp_ready});
         tick();
         chk($sformatf("v%0d rsp_valid", i), {28'h0, rsp_valid}, {28'h0, vecs[i].exp_rv});
         if (vecs[i].dmask != 4'h0)
            chk($sformatf("v%0d rsp_data", i), rsp_data & lanes(vecs[i].dmask),
                vecs[i].exp_data & lanes(vecs[i].dmask));
      end

      // Stalled response on req1: it is skipped until its slot drains.
      drive(1'b1, 4'h0, 4'h0, 4'hF, 32'h0, 32'h0);
      tick();
      exp_g = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h4, 4'h8, 4'h1, 4'h2};
      for (int c = 0; c < 9; c++) begin
         drive(1'b0, 4'hF, 4'b1101, (c < 6) ? 4'hD : 4'hF, 32'h10101010, 32'h33220011);
         #1;
         chk($sformatf("stall c%0d req_ready", c), {28'h0, req_ready}, {28'h0, exp_g[c]});
         tick();
         if (c == 0) chk("stall c0 rsp_data0", {24'h0, rsp_data[7:0]}, 32'h3C);
         if (c == 4) chk("stall c4 rsp_data0", {24'h0, rsp_data[7:0]}, 32'h33);
         if ((c >= 1 && c <= 5) || c == 8) begin
            chk($sformatf("stall c%0d rsp_valid1", c), {31'h0, rsp_valid[1]}, 32'h1);
            chk($sformatf("stall c%0d rsp_data1", c), {24'h0, rsp_data[15:8]}, 32'h11);
         end
         if (c == 6) chk("stall c6 rsp_valid1", {31'h0, rsp_valid[1]}, 32'h0);
      end

      // Move ptr to 3, grant lone req1, then reset with its response pending.
      drive(1'b0, 4'h0, 4'h0, 4'hF, 32'h10101010, 32'h0);
      tick();
      chk("drain rsp_valid", {28'h0, rsp_valid}, 32'h0);
      drive(1'b0, 4'h4, 4'h0, 4'hF, 32'h10101010, 32'h0);
      #1;
      chk("p2 req_ready", {28'h0, req_ready}, 32'h4);
      tick();
      drive(1'b0, 4'h0, 4'h0, 4'hF, 32'h10101010, 32'h0);
      tick();
      chk("ptr3 value", {30'h0, dut.ptr_r}, 32'h3);
      drive(1'b0, 4'h2, 4'h0, 4'hF, 32'h10101010, 32'h0);
      #1;
      chk("ptr3 req_ready", {28'h0, req_ready}, 32'h2);
      tick();
      chk("ptr after grant1", {30'h0, dut.ptr_r}, 32'h2);
      chk("grant1 rsp_valid", {28'h0, rsp_valid}, 32'h2);
      chk("grant1 rsp_data1", {24'h0, rsp_data[15:8]}, 32'h11);
      drive(1'b1, 4'h6, 4'h0, 4'h0, 32'h10101010, 32'h0);
      #1;
      chk("rst req_ready", {28'h0, req_ready}, 32'h0);
      tick();
      chk("rst rsp_valid", {28'h0, rsp_valid}, 32'h0);
      chk("rst rsp_data", rsp_data, 32'h0);
      chk("rst ptr", {30'h0, dut.ptr_r}, 32'h0);
      drive(1'b0, 4'h6, 4'h0, 4'hF, 32'h10101010, 32'h0);
      #1;
      chk("post-rst req_ready", {28'h0, req_ready}, 32'h2);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
